// File: rtl/line_buffer_scan_sequencer_if.sv
// Purpose : bundles the start/ready handshake, frame-memory read port and
//           line-buffer output port of line_buffer_scan_sequencer.
// Ports   : master = sequencer side (drives addr, pixel/count/valid, busy, done);
//           slave  = environment side (drives start, ready, returned pixel).
interface line_buffer_scan_sequencer_if;
  logic               start_in;
  logic               ready_in;
  logic [9:0]         addr_out;
  logic signed [20:0] pixel_data_in;
  logic signed [20:0] pixel_data_out;
  logic [4:0]         hcount_out;
  logic [4:0]         vcount_out;
  logic               data_valid_out;
  logic               busy_out;
  logic               done_out;

  modport master (
    input  start_in, ready_in, pixel_data_in,
    output addr_out, pixel_data_out, hcount_out, vcount_out,
    output data_valid_out, busy_out, done_out
  );

  modport slave (
    output start_in, ready_in, pixel_data_in,
    input  addr_out, pixel_data_out, hcount_out, vcount_out,
    input  data_valid_out, busy_out, done_out
  );
endinterface

// File: rtl/line_buffer_scan_sequencer.sv
// Purpose : raster-scan read sequencer feeding the rolling line buffer from frame memory.
// Latency : pixel issued (addr_out) in cycle t appears on data_valid_out in cycle t+READ_LAT.
// Backpr. : ready_in=0 in SCAN/FLUSH holds counters and injects a bubble; GAP/DRAIN ignore ready_in.
//
// Ports: clk_in, rst_in (async active-low); bus (master modport) carries
//   start_in/ready_in handshake, addr_out/pixel_data_in memory port,
//   pixel_data_out/hcount_out/vcount_out/data_valid_out to the line buffer,
//   busy_out/done_out frame status.
// Optional feature: define SEQ_FLUSH_EN to append FLUSH_ROWS rows of zero
//   pixels after the last image row (pushes bottom rows out of the line buffer).
module line_buffer_scan_sequencer #(
  parameter int WIDTH      = 24,
  parameter int HEIGHT     = 32,
  parameter int READ_LAT   = 2,
  parameter int LINE_GAP   = 2,
  parameter int FLUSH_ROWS = 5
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  line_buffer_scan_sequencer_if.master  bus
);

  if (READ_LAT < 1 || LINE_GAP < 1 || FLUSH_ROWS < 0 || FLUSH_ROWS > 255) begin : g_param_check
    $error("line_buffer_scan_sequencer: READ_LAT/LINE_GAP must be >=1, FLUSH_ROWS 0..255");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef SEQ_FLUSH_EN
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [7:0] FLUSH_N = 8'(FLUSH_ROWS);
`endif

  localparam logic [4:0] H_LAST     = 5'(WIDTH - 1);
  localparam logic [4:0] V_LAST     = 5'(HEIGHT - 1);
  localparam logic [7:0] GAP_LAST   = 8'(LINE_GAP - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(READ_LAT - 1);
  localparam logic [9:0] W10        = 10'(WIDTH);

  // Tag travelling alongside each memory read; zero marks flush beats that
  // carry no memory data.
  typedef struct packed {
    logic       vld;
    logic       zero;
    logic [4:0] h;
    logic [4:0] v;
  } tag_t;

  logic [2:0] state;
  logic [4:0] h;
  logic [4:0] v;
  logic [7:0] gap_cnt;
  logic [7:0] drain_cnt;
  logic       busy;
  logic       done;
  tag_t       pipe [READ_LAT];
  tag_t       tag_in;
  tag_t       tag_out;
  logic       issue;
  logic       fill;
  logic [9:0] addr_calc;
`ifdef SEQ_FLUSH_EN
  logic       in_flush;
  logic [7:0] flush_cnt;
`endif

  always_comb begin
    issue = (state == S_SCAN) && bus.ready_in;
    fill  = 1'b0;
`ifdef SEQ_FLUSH_EN
    fill  = (state == S_FLUSH) && bus.ready_in;
`endif
    tag_in      = '0;
    tag_in.vld  = issue | fill;
    tag_in.zero = fill;
    tag_in.h    = h;
    tag_in.v    = v;
  end

  // 10-bit product is exact for the default geometry (max 767).
  assign addr_calc = 10'(v) * W10 + 10'(h);
  assign tag_out   = pipe[READ_LAT-1];

  assign bus.addr_out       = issue ? addr_calc : '0;
  assign bus.data_valid_out = tag_out.vld;
  assign bus.hcount_out     = tag_out.vld ? tag_out.h : '0;
  assign bus.vcount_out     = tag_out.vld ? tag_out.v : '0;
  // Memory data arrives exactly when its tag reaches the last stage, so it
  // passes straight through; flush beats and bubbles are forced to zero.
  assign bus.pixel_data_out = (tag_out.vld && !tag_out.zero) ? bus.pixel_data_in : '0;
  assign bus.busy_out       = busy;
  assign bus.done_out       = done;

  // Tag pipe: one stage per cycle of memory read latency.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= S_IDLE;
      h         <= '0;
      v         <= '0;
      gap_cnt   <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_FLUSH_EN
      in_flush  <= 1'b0;
      flush_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_in) begin
            state <= S_SCAN;
            h     <= '0;
            v     <= '0;
            busy  <= 1'b1;
`ifdef SEQ_FLUSH_EN
            in_flush  <= 1'b0;
            flush_cnt <= '0;
`endif
          end
        end

        S_SCAN: begin
          if (bus.ready_in) begin
            if (h == H_LAST) begin
              h <= '0;
              if (v == V_LAST) begin
`ifdef SEQ_FLUSH_EN
                // Flush rows keep counting rows past the image, wrapping mod 32.
                v        <= v + 5'd1;
                in_flush <= 1'b1;
                gap_cnt  <= '0;
                state    <= S_GAP;
`else
                drain_cnt <= '0;
                state     <= S_DRAIN;
`endif
              end else begin
                v       <= v + 5'd1;
                gap_cnt <= '0;
                state   <= S_GAP;
              end
            end else begin
              h <= h + 5'd1;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
`ifdef SEQ_FLUSH_EN
            if (in_flush) begin
              if (flush_cnt == FLUSH_N) begin
                drain_cnt <= '0;
                state     <= S_DRAIN;
              end else begin
                state <= S_FLUSH;
              end
            end else begin
              state <= S_SCAN;
            end
`else
            state <= S_SCAN;
`endif
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

`ifdef SEQ_FLUSH_EN
        S_FLUSH: begin
          if (bus.ready_in) begin
            if (h == H_LAST) begin
              h         <= '0;
              v         <= v + 5'd1;
              flush_cnt <= flush_cnt + 8'd1;
              gap_cnt   <= '0;
              state     <= S_GAP;
            end else begin
              h <= h + 5'd1;
            end
          end
        end
`endif

        S_DRAIN: begin
          // READ_LAT cycles lets the last tag leave the pipe before done.
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_scan_sequencer.sv
// Purpose : self-checking bench for line_buffer_scan_sequencer (default geometry 24x32, READ_LAT=2, LINE_GAP=2).
// Latency : memory model returns the address as the pixel two cycles after it is issued.
// Backpr. : ready_in is driven by a cycle table and by stall windows keyed off observed output beats.
module tb_line_buffer_scan_sequencer;

  localparam int WIDTH    = 24;
  localparam int HEIGHT   = 32;
  localparam int LINE_GAP = 2;
`ifdef SEQ_FLUSH_EN
  localparam int TOTAL_BEATS = 888;
`else
  localparam int TOTAL_BEATS = 768;
`endif

  logic clk_in = 1'b0;
  logic rst_in;
  int   checks = 0;
  int   errors = 0;

  line_buffer_scan_sequencer_if bus ();

  line_buffer_scan_sequencer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Frame memory: returns the issued address as the pixel, READ_LAT=2 later.
  logic [9:0] mem_q [2];
  always @(posedge clk_in) begin
    mem_q[0] <= bus.addr_out;
    mem_q[1] <= mem_q[0];
  end
  assign bus.pixel_data_in = 21'(mem_q[1]);

  typedef struct {
    logic       start;
    logic       ready;
    int         addr;
    logic       vld;
    int         h;
    int         v;
    int         pix;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs [13];

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outputs_nonzero();
    return int'(bus.addr_out != 0) + int'(bus.pixel_data_out != 0) + int'(bus.hcount_out != 0)
         + int'(bus.vcount_out != 0) + int'(bus.data_valid_out) + int'(bus.busy_out)
         + int'(bus.done_out);
  endfunction

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    bus.start_in = 1'b0;
    bus.ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic run_frame(input bit do_stall, input bit do_abort, input bit hold_start);
    int beats = 0, bad = 0, dones = 0, busy_low = 0, busy_at_done = -1;
    int gap_min = 1000, gap_max = -1, inv_run = 0, row3_inv = 0, stall_left = 0;
    int idx, exp_h, exp_v, exp_pix;
    bit finished = 0, aborted = 0;
    @(posedge clk_in); #1;
    bus.start_in = 1'b1;
    bus.ready_in = 1'b1;
    @(posedge clk_in); #1;
    if (!hold_start) bus.start_in = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk_in); #1;
        bus.ready_in = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      @(negedge clk_in);
      if (bus.data_valid_out) begin
        idx     = beats;
        exp_h   = idx % WIDTH;
        exp_v   = (idx / WIDTH) % 32;
        exp_pix = (idx < WIDTH * HEIGHT) ? idx : 0;
        if (int'(bus.hcount_out) != exp_h || int'(bus.vcount_out) != exp_v
            || int'(bus.pixel_data_out) != exp_pix) bad++;
        if (idx > 0) begin
          if (exp_h == 0) begin
            if (inv_run < gap_min) gap_min = inv_run;
            if (inv_run > gap_max) gap_max = inv_run;
          end else if (exp_v == 3 && idx < WIDTH * HEIGHT) begin
            row3_inv += inv_run;
          end
        end
        inv_run = 0;
        beats++;
        if (do_stall && exp_v == 3 && exp_h == 10 && idx < WIDTH * HEIGHT) stall_left = 5;
        if (do_abort && exp_v == 10 && exp_h == 7) begin
          rst_in = 1'b0;
          #1;
          check_eq("abort_outputs_zero", outputs_nonzero(), 0);
          aborted  = 1;
          finished = 1;
        end
      end else if (beats > 0) begin
        inv_run++;
      end
      if (!aborted) begin
        if (bus.done_out) begin
          dones++;
          busy_at_done = int'(bus.busy_out);
          finished = 1;
        end else if (!bus.busy_out) begin
          busy_low++;
        end
      end
    end
    check_eq("frame_terminated", int'(finished), 1);
    check_eq("beat_count", beats, do_abort ? 248 : TOTAL_BEATS);
    check_eq("beat_content_errors", bad, 0);
    check_eq("gap_min", gap_min, LINE_GAP);
    check_eq("gap_max", gap_max, LINE_GAP);
    check_eq("row3_invalid_beats", row3_inv, do_stall ? 5 : 0);
    check_eq("busy_drop_mid_frame", busy_low, 0);
    if (do_abort) begin
      repeat (2) begin
        @(negedge clk_in);
        if (bus.done_out) dones++;
      end
      check_eq("abort_done_pulses", dones, 0);
      check_eq("abort_busy", int'(bus.busy_out), 0);
    end else begin
      check_eq("done_pulses", dones, 1);
      check_eq("busy_at_done", busy_at_done, 0);
    end
    if (hold_start) begin
      @(negedge clk_in);
      check_eq("restart_busy_after_idle", int'(bus.busy_out), 1);
      check_eq("restart_no_second_done", int'(bus.done_out), 0);
    end
  endtask

  initial begin
    // start ready  addr vld h  v  pix busy done
    vecs[0]  = '{1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1, 1'b0, 0, 0, 0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 0, 1'b1, 0, 0, 0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2, 1'b1, 1, 0, 1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3, 1'b0, 0, 0, 0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4, 1'b1, 2, 0, 2, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 0, 1'b1, 3, 0, 3, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 0, 1'b1, 4, 0, 4, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 5, 1'b0, 0, 0, 0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 6, 1'b0, 0, 0, 0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 7, 1'b1, 5, 0, 5, 1'b1, 1'b0};

    rst_in       = 1'b0;
    bus.start_in = 1'b0;
    bus.ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_eq("reset_outputs_zero", outputs_nonzero(), 0);
    rst_in = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(posedge clk_in); #1;
      bus.start_in = vecs[i].start;
      bus.ready_in = vecs[i].ready;
      @(negedge clk_in);
      if (int'(bus.addr_out) != vecs[i].addr || bus.data_valid_out != vecs[i].vld
          || int'(bus.hcount_out) != vecs[i].h || int'(bus.vcount_out) != vecs[i].v
          || int'(bus.pixel_data_out) != vecs[i].pix || bus.busy_out != vecs[i].busy
          || bus.done_out != vecs[i].done) begin
        errors++;
        $display("FAIL vec%0d: got addr=%0d vld=%0b h=%0d v=%0d pix=%0d busy=%0b done=%0b, expected addr=%0d vld=%0b h=%0d v=%0d pix=%0d busy=%0b done=%0b",
                 i, bus.addr_out, bus.data_valid_out, bus.hcount_out, bus.vcount_out,
                 bus.pixel_data_out, bus.busy_out, bus.done_out, vecs[i].addr, vecs[i].vld,
                 vecs[i].h, vecs[i].v, vecs[i].pix, vecs[i].busy, vecs[i].done);
      end
      checks++;
    end

    do_reset();
    run_frame(1'b0, 1'b0, 1'b0);   // clean full frame
    do_reset();
    run_frame(1'b1, 1'b0, 1'b0);   // 5-cycle stall inside row 3
    do_reset();
    run_frame(1'b0, 1'b1, 1'b0);   // reset at row 10 col 7
    rst_in = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0);   // restart after abort
    do_reset();
    run_frame(1'b0, 1'b0, 1'b1);   // start held across done
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
